// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: decodes PS/2 scan-code prefixes, filters typematic repeats
// and queues complete key events for the processor to drain.
module ps2_key_event_ctrl #(
    parameter int DEPTH           = 4,
    parameter int AW              = 2,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic          clk_Nexys,
    input  logic          Reset,
    input  logic [7:0]    byte_dato,
    input  logic          scan_done_tick,
    input  logic          rd_tick,
    input  logic          clr_ovf,
    output logic [7:0]    evt_code,
    output logic          evt_ext,
    output logic          evt_break,
    output logic          evt_valid,
    output logic          fifo_full,
    output logic [AW:0]   fifo_count,
    output logic          ovf
);
    // bit 0 marks a pending E0, bit 1 a pending F0, so prefixes simply OR in
    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] GOT_E0   = 2'b01;
    localparam logic [1:0] GOT_F0   = 2'b10;
    localparam logic [1:0] GOT_E0F0 = 2'b11;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [1:0]    state, state_nxt;
    logic          held;
    logic [8:0]    last_make;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [9:0]    mem [DEPTH];
    logic          is_ctrl, is_e0, is_f0, is_data;
    logic          make, brk, rep, push, pop, do_push, ovf_set;
    logic [8:0]    key;

    assign is_ctrl = byte_dato inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    assign is_e0   = byte_dato == 8'hE0;
    assign is_f0   = byte_dato == 8'hF0;
    assign is_data = scan_done_tick & ~is_ctrl & ~is_e0 & ~is_f0;
    assign key     = {state[0], byte_dato};
    assign make    = is_data & ~state[1];
    assign brk     = is_data & state[1];
    assign rep     = SUPPRESS_REPEAT & make & held & (key == last_make);
    assign push    = (make & ~rep) | brk;
    assign pop     = rd_tick & (count != '0);
    assign do_push = push & (~fifo_full | pop);
    assign ovf_set = push & fifo_full & ~pop;

    always_comb
        state_nxt = !scan_done_tick ? state :
                    is_ctrl         ? IDLE :
                    is_e0           ? (state | GOT_E0) :
                    is_f0           ? (state | GOT_F0) : IDLE;

    always_ff @(posedge clk_Nexys or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            held      <= 1'b0;
            last_make <= 9'h000;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (make && !rep) begin
                last_make <= key;
                held      <= 1'b1;
            end else if (brk && key == last_make) begin
                held <= 1'b0;
            end
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, pop};
            ovf   <= ovf_set ? 1'b1 : clr_ovf ? 1'b0 : ovf;
        end
    end

    // storage needs no reset: the head is masked whenever the queue is empty
    always_ff @(posedge clk_Nexys)
        if (do_push)
            mem[wr_ptr] <= {brk, key};

    assign evt_valid  = count != '0;
    assign fifo_full  = count == FULL_CNT;
    assign fifo_count = count;
    assign {evt_break, evt_ext, evt_code} = evt_valid ? mem[rd_ptr] : 10'h000;
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl: directed checks of prefix decoding, repeat filtering,
// FIFO ordering, overflow and reset behaviour.
module tb_ps2_key_event_ctrl;
    logic       clk_Nexys = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] byte_dato = 8'h00;
    logic       scan_done_tick = 1'b0;
    logic       rd_tick = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] evt_code;
    logic       evt_ext, evt_break, evt_valid, fifo_full, ovf;
    logic [2:0] fifo_count;
    int         vectors = 0;
    int         miscompares = 0;

    ps2_key_event_ctrl dut (
        .clk_Nexys(clk_Nexys), .Reset(Reset), .byte_dato(byte_dato),
        .scan_done_tick(scan_done_tick), .rd_tick(rd_tick), .clr_ovf(clr_ovf),
        .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
        .evt_valid(evt_valid), .fifo_full(fifo_full), .fifo_count(fifo_count),
        .ovf(ovf)
    );

    always #5 clk_Nexys = ~clk_Nexys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk_Nexys);
        byte_dato = b;
        scan_done_tick = 1'b1;
        @(negedge clk_Nexys);
        scan_done_tick = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk_Nexys);
        rd_tick = 1'b1;
        @(negedge clk_Nexys);
        rd_tick = 1'b0;
    endtask

    function automatic logic [31:0] outs();
        return {17'd0, evt_code, evt_ext, evt_break, evt_valid, fifo_full, fifo_count, ovf};
    endfunction

    function automatic logic [31:0] head();
        return {22'd0, evt_break, evt_ext, evt_code};
    endfunction

    initial begin
        repeat (3) @(negedge clk_Nexys);
        chk("reset_outs", outs(), 0);
        Reset = 1'b1;

        send(8'h1C);
        chk("first_valid", {31'd0, evt_valid}, 1);
        chk("first_head", head(), 10'h01C);
        chk("first_count", fifo_count, 1);
        pop();
        chk("first_popped", {23'd0, evt_valid, evt_code}, 0);

        send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h75);
        chk("seq_count", fifo_count, 3);
        chk("seq_head0", head(), 10'h21C);
        pop();
        chk("seq_head1", head(), 10'h375);
        pop();
        chk("seq_head2", head(), 10'h175);
        pop();
        chk("seq_empty", fifo_count, 0);

        send(8'h1C);
        send(8'hFA);
        chk("ctrl_no_push", fifo_count, 1);
        send(8'h1C); send(8'h1C);
        chk("repeat_dropped", fifo_count, 1);
        send(8'hF0); send(8'h1C); send(8'h1C);
        chk("rep_count", fifo_count, 3);
        chk("rep_head0", head(), 10'h01C);
        pop();
        chk("rep_head1", head(), 10'h21C);
        pop();
        chk("rep_head2", head(), 10'h01C);
        pop();
        pop();
        chk("pop_empty_ignored", fifo_count, 0);

        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_full", {31'd0, fifo_full}, 1);
        chk("ovf_flag", {31'd0, ovf}, 1);
        chk("ovf_head", evt_code, 8'h15);
        @(negedge clk_Nexys);
        byte_dato = 8'h2B; scan_done_tick = 1'b1; rd_tick = 1'b1;
        @(negedge clk_Nexys);
        scan_done_tick = 1'b0; rd_tick = 1'b0;
        chk("full_pushpop_count", fifo_count, 4);
        chk("full_pushpop_head", evt_code, 8'h1D);
        chk("full_pushpop_ovf", {31'd0, ovf}, 1);
        @(negedge clk_Nexys);
        clr_ovf = 1'b1;
        @(negedge clk_Nexys);
        clr_ovf = 1'b0;
        chk("ovf_cleared", {31'd0, ovf}, 0);
        pop();
        chk("drain1", evt_code, 8'h24);
        pop();
        chk("drain2", evt_code, 8'h2D);
        pop();
        chk("drain3", evt_code, 8'h2B);
        pop();
        chk("drained", fifo_count, 0);

        for (int i = 0; i < 10; i++) begin
            send(8'h21 + 8'(i));
            chk("wrap_count", fifo_count, 1);
            chk("wrap_head", head(), 32'h21 + i);
            pop();
            chk("wrap_empty", fifo_count, 0);
        end

        @(negedge clk_Nexys);
        byte_dato = 8'h33; scan_done_tick = 1'b1; rd_tick = 1'b1;
        @(negedge clk_Nexys);
        scan_done_tick = 1'b0; rd_tick = 1'b0;
        chk("empty_pushpop_count", fifo_count, 1);
        chk("empty_pushpop_head", head(), 10'h033);
        pop();

        send(8'h1B);
        send(8'hE0);
        #2 Reset = 1'b0;
        #1 chk("async_reset_outs", outs(), 0);
        @(negedge clk_Nexys);
        Reset = 1'b1;
        send(8'h75);
        chk("post_reset_head", head(), 10'h075);
        chk("post_reset_count", fifo_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Sequences the keyboard path between the PS/2 byte receiver and the PicoBlaze port interface.
- Consumes raw scan-code bytes and tracks E0 (extended) and F0 (break) prefixes with a state machine.
- Suppresses typematic auto-repeat, then queues complete key events in a small FIFO that the processor drains with a read strobe.
- Reports status: valid, full, occupancy and sticky overflow.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 2, log2(DEPTH); occupancy width is AW+1.
- SUPPRESS_REPEAT, 1, 1 = drop repeated makes of a held key; 0 = pass every make.

Ports:
- clk_Nexys  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-low reset (Reset = 0 resets).
- byte_dato  in  8  received scan-code byte; valid only while scan_done_tick = 1.
- scan_done_tick  in  1  one-cycle strobe, byte available.
- rd_tick  in  1  one-cycle pop of the FIFO head.
- clr_ovf  in  1  one-cycle clear of ovf.
- evt_code  out  8  head event scan code.
- evt_ext  out  1  head event was E0-prefixed.
- evt_break  out  1  head event is a release.
- evt_valid  out  1  FIFO not empty.
- fifo_full  out  1  occupancy = DEPTH.
- fifo_count  out  AW+1  occupancy 0..DEPTH.
- ovf  out  1  sticky; set when an event is dropped because the FIFO is full.

Behaviour:
- Reset (async, Reset = 0):
  - FSM to IDLE; FIFO pointers and count to 0; ovf = 0; held = 0; last_make = 9'h000.
  - All outputs 0.
  - Reset mid-sequence discards any partial prefix.
- Control bytes: 00, AA, E1, EE, FA, FC, FE, FF. In any state these cause no push, and the FSM goes to IDLE.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions are evaluated only on cycles with scan_done_tick = 1.
  - IDLE:
    - E0 -> GOT_E0.
    - F0 -> GOT_F0.
    - Other non-control byte -> make candidate {ext=0, code}, stay IDLE.
  - GOT_E0:
    - F0 -> GOT_E0F0.
    - E0 -> stay.
    - Other -> make candidate {ext=1, code}, go to IDLE.
  - GOT_F0:
    - F0 -> stay.
    - E0 -> GOT_E0F0.
    - Other -> break candidate {ext=0}, go to IDLE.
  - GOT_E0F0:
    - F0 or E0 -> stay.
    - Other -> break candidate {ext=1}, go to IDLE.
- Repeat filter (applies only when SUPPRESS_REPEAT = 1):
  - Make with held = 1 and {ext,code} = last_make -> dropped, no push.
  - Any other make -> last_make <= {ext,code}, held <= 1, push.
  - Break matching last_make -> held <= 0.
  - Every break is pushed.
- Latency: an event pushed on the cycle of its final byte's tick appears at the head on the next cycle (evt_valid rises then if the FIFO was empty).
- FIFO:
  - First-in first-out, circular pointers of AW bits, wrapping DEPTH-1 -> 0.
  - Count is a separate AW+1-bit register.
  - Pop on rd_tick when not empty.
  - rd_tick while empty -> ignored; count and pointers unchanged.
  - Push when full without a same-cycle pop -> event dropped, ovf <= 1.
  - Push and pop on the same cycle when full -> both performed, count unchanged, ovf unchanged.
  - Push and pop on the same cycle when empty -> push only; count becomes 1.
- evt_code, evt_ext, evt_break:
  - Show the head entry when evt_valid = 1.
  - Forced to 0 when evt_valid = 0.
- clr_ovf clears ovf. If clr_ovf and a new overflow occur in the same cycle, the set wins (ovf = 1).

Test Plan:
- Reset low 3 cycles then high; send 1C -> one cycle after the tick: evt_valid = 1, evt_code = 1C, evt_ext = 0, evt_break = 0, fifo_count = 1. Pulse rd_tick -> evt_valid = 0, evt_code = 00.
- Send F0, 1C; then E0, F0, 75; then E0, 75 -> three events in order: {1C,ext0,brk1}, {75,ext1,brk1}, {75,ext1,brk0}; fifo_count = 3.
- Repeat filter (SUPPRESS_REPEAT = 1): send 1C, 1C, 1C, F0, 1C, 1C -> exactly three events: make 1C, break 1C, make 1C. Control byte FA between bytes -> no push.
- Overflow (DEPTH = 4): makes 15, 1D, 24, 2D, 2C with no reads -> fifo_count = 4, fifo_full = 1, ovf = 1, evt_code = 15.
  - Then send 2B with rd_tick on the same cycle as its tick -> fifo_count stays 4, head = 1D.
  - Then clr_ovf -> ovf = 0.
- Wrap-around: 10 alternating push/pop cycles with distinct codes 21..2A -> every popped code matches push order; fifo_count never exceeds 1.
- Reset asserted low immediately after E0 is received -> all outputs 0. After release, send 75 -> event {75,ext0,brk0}.
